// File: rtl/hamming_secded_decoder_if.sv
// Stream interface of the extended-Hamming SECDED decoder: codeword in, corrected data and
// error status out, plus the error-counter controls.
interface hamming_secded_decoder_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
);
    function automatic int unsigned calc_p(input int unsigned dw);
        int unsigned p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    localparam int unsigned P         = calc_p(DATA_WIDTH);
    localparam int unsigned CW_WIDTH  = DATA_WIDTH + P + 1;
    localparam int unsigned POS_WIDTH = $clog2(CW_WIDTH);

    logic                  i_valid;
    logic                  o_ready;
    logic [CW_WIDTH-1:0]   i_codeword;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_sec;
    logic                  o_ded;
    logic [POS_WIDTH-1:0]  o_err_pos;
    logic                  i_clr_cnt;
    logic [CNT_WIDTH-1:0]  o_sec_count;
    logic [CNT_WIDTH-1:0]  o_ded_count;

    // Decoder side.
    modport slave (
        input  i_valid, i_codeword, i_ready, i_clr_cnt,
        output o_ready, o_valid, o_data, o_sec, o_ded, o_err_pos, o_sec_count, o_ded_count
    );

    // Producer/consumer side.
    modport master (
        output i_valid, i_codeword, i_ready, i_clr_cnt,
        input  o_ready, o_valid, o_data, o_sec, o_ded, o_err_pos, o_sec_count, o_ded_count
    );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined extended-Hamming SECDED decoder with valid/ready flow control and
// saturating SEC/DED event counters.
module hamming_secded_decoder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic                     i_clk,
    input logic                     i_rst_n,
    hamming_secded_decoder_if.slave bus
);
    function automatic int unsigned calc_p(input int unsigned dw);
        int unsigned p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    localparam int unsigned P         = calc_p(DATA_WIDTH);
    localparam int unsigned CW_WIDTH  = DATA_WIDTH + P + 1;
    localparam int unsigned POS_WIDTH = $clog2(CW_WIDTH);

    // Data bits occupy the non-power-of-two positions above 0, LSB first.
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [CW_WIDTH-1:0] cw);
        logic [DATA_WIDTH-1:0] d;
        int unsigned           k;
        d = '0;
        k = 0;
        for (int unsigned i = 1; i < CW_WIDTH; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[k] = cw[i];
                k++;
            end
        end
        return d;
    endfunction

    logic                  s2_free;
    logic                  o_ready;
    logic                  in_fire;
    logic                  out_fire;

    logic [P-1:0]          syn_d;
    logic                  par_d;

    logic                  s1_valid_q;
    logic [P-1:0]          s1_syn_q;
    logic                  s1_par_q;
    logic [CW_WIDTH-1:0]   s1_cw_q;

    logic [CW_WIDTH-1:0]   fixed_cw;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  sec_d;
    logic                  ded_d;
    logic [POS_WIDTH-1:0]  pos_d;

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  sec_q;
    logic                  ded_q;
    logic [POS_WIDTH-1:0]  pos_q;
    logic [CNT_WIDTH-1:0]  sec_cnt_q;
    logic [CNT_WIDTH-1:0]  ded_cnt_q;

    assign s2_free  = !valid_q || bus.i_ready;
    assign o_ready  = !s1_valid_q || s2_free;
    assign in_fire  = bus.i_valid && o_ready;
    assign out_fire = valid_q && bus.i_ready;

    always_comb begin
        syn_d = '0;
        for (int unsigned i = 1; i < CW_WIDTH; i++) begin
            if (bus.i_codeword[i]) syn_d = syn_d ^ P'(i);
        end
        par_d = ^bus.i_codeword;
    end

    always_comb begin
        fixed_cw = s1_cw_q;
        sec_d    = 1'b0;
        ded_d    = 1'b0;
        pos_d    = '0;
        if (s1_syn_q == '0) begin
            // Odd parity with zero syndrome: only the overall parity bit flipped.
            sec_d = s1_par_q;
        end else if (s1_par_q && (32'(s1_syn_q) <= CW_WIDTH - 1)) begin
            sec_d           = 1'b1;
            pos_d           = POS_WIDTH'(s1_syn_q);
            fixed_cw[pos_d] = ~fixed_cw[pos_d];
        end else begin
            ded_d = 1'b1;
        end
        data_d = extract(fixed_cw);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            s1_cw_q    <= '0;
        end else begin
            if (o_ready) s1_valid_q <= bus.i_valid;
            if (in_fire) begin
                s1_syn_q <= syn_d;
                s1_par_q <= par_d;
                s1_cw_q  <= bus.i_codeword;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sec_q   <= 1'b0;
            ded_q   <= 1'b0;
            pos_q   <= '0;
        end else if (s2_free) begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q <= data_d;
                sec_q  <= sec_d;
                ded_q  <= ded_d;
                pos_q  <= pos_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else if (bus.i_clr_cnt) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else if (out_fire) begin
            if (sec_q && (sec_cnt_q != '1)) sec_cnt_q <= sec_cnt_q + CNT_WIDTH'(1);
            if (ded_q && (ded_cnt_q != '1)) ded_cnt_q <= ded_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.o_ready     = o_ready;
    assign bus.o_valid     = valid_q;
    assign bus.o_data      = data_q;
    assign bus.o_sec       = sec_q;
    assign bus.o_ded       = ded_q;
    assign bus.o_err_pos   = pos_q;
    assign bus.o_sec_count = sec_cnt_q;
    assign bus.o_ded_count = ded_cnt_q;
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder (DATA_WIDTH=8): vector table, backpressure,
// counter saturation/clear on a CNT_WIDTH=2 twin, and asynchronous reset.
module tb_hamming_secded_decoder;
    logic clk;
    logic rst_n;

    hamming_secded_decoder_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dif ();
    hamming_secded_decoder_if #(.DATA_WIDTH(8), .CNT_WIDTH(2))  sif ();

    hamming_secded_decoder #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (dif)
    );

    hamming_secded_decoder #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (sif)
    );

    // The saturation twin sees exactly the same traffic as the main instance.
    assign sif.i_valid    = dif.i_valid;
    assign sif.i_codeword = dif.i_codeword;
    assign sif.i_ready    = dif.i_ready;
    assign sif.i_clr_cnt  = dif.i_clr_cnt;

    typedef struct {
        logic [12:0] cw;
        logic [7:0]  data;
        logic        sec;
        logic        ded;
        logic [3:0]  pos;
    } vec_t;

    vec_t        vecs [12];
    logic [12:0] bp_cw [3];
    logic [7:0]  bp_data [3];
    logic        bp_sec [3];
    int          n_cmp;
    int          n_bad;
    int          exp_sec;
    int          exp_ded;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, ".sec_cnt"}, 32'(dif.o_sec_count), 32'(exp_sec));
        chk({tag, ".ded_cnt"}, 32'(dif.o_ded_count), 32'(exp_ded));
        chk({tag, ".sat_sec_cnt"}, 32'(sif.o_sec_count), 32'(sat3(exp_sec)));
        chk({tag, ".sat_ded_cnt"}, 32'(sif.o_ded_count), 32'(sat3(exp_ded)));
    endtask

    // One word through an idle pipeline with i_ready=1; optionally clear the counters in the
    // same cycle as its output transfer.
    task automatic apply(input string tag, input logic [12:0] cw, input logic [7:0] edata,
                         input logic esec, input logic eded, input logic [3:0] epos,
                         input bit clr);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(dif.o_ready), 32'd1);
        dif.i_valid    = 1'b1;
        dif.i_codeword = cw;
        @(negedge clk);
        dif.i_valid = 1'b0;
        lat = 1;
        while (!dif.o_valid && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd2);
        chk({tag, ".data"}, 32'(dif.o_data), 32'(edata));
        chk({tag, ".sec"}, 32'(dif.o_sec), 32'(esec));
        chk({tag, ".ded"}, 32'(dif.o_ded), 32'(eded));
        if (esec) chk({tag, ".pos"}, 32'(dif.o_err_pos), 32'(epos));
        chk({tag, ".excl"}, 32'(dif.o_sec && dif.o_ded), 32'd0);
        if (clr) begin
            dif.i_clr_cnt = 1'b1;
            exp_sec = 0;
            exp_ded = 0;
        end else begin
            exp_sec += int'(esec);
            exp_ded += int'(eded);
        end
        @(negedge clk);
        dif.i_clr_cnt = 1'b0;
        chk({tag, ".drained"}, 32'(dif.o_valid), 32'd0);
        check_counts(tag);
    endtask

    initial begin
        int   idx;
        int   nout;
        int   out_cyc [3];
        logic [7:0] out_dat [3];
        logic out_sec [3];

        n_cmp   = 0;
        n_bad   = 0;
        exp_sec = 0;
        exp_ded = 0;

        // Clean A5 encodes as 0x144E (data at 3,6,10,12; check bits 1,2).
        vecs[0]  = '{13'h0000, 8'h00, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{13'h0020, 8'h00, 1'b1, 1'b0, 4'd5};
        vecs[2]  = '{13'h0008, 8'h00, 1'b1, 1'b0, 4'd3};
        vecs[3]  = '{13'h0001, 8'h00, 1'b1, 1'b0, 4'd0};
        vecs[4]  = '{13'h0028, 8'h03, 1'b0, 1'b1, 4'd0};  // positions 3,5 carry d0,d1
        vecs[5]  = '{13'h0112, 8'h00, 1'b0, 1'b1, 4'd0};
        vecs[6]  = '{13'h144E, 8'hA5, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{13'h104E, 8'hA5, 1'b1, 1'b0, 4'd10};
        vecs[8]  = '{13'h144A, 8'hA5, 1'b1, 1'b0, 4'd2};
        vecs[9]  = '{13'h044E, 8'hA5, 1'b1, 1'b0, 4'd12};
        vecs[10] = '{13'h144F, 8'hA5, 1'b1, 1'b0, 4'd0};
        vecs[11] = '{13'h0446, 8'h24, 1'b0, 1'b1, 4'd0};

        bp_cw[0] = 13'h144E; bp_data[0] = 8'hA5; bp_sec[0] = 1'b0;
        bp_cw[1] = 13'h0000; bp_data[1] = 8'h00; bp_sec[1] = 1'b0;
        bp_cw[2] = 13'h144F; bp_data[2] = 8'hA5; bp_sec[2] = 1'b1;

        rst_n          = 1'b0;
        dif.i_valid    = 1'b0;
        dif.i_codeword = '0;
        dif.i_ready    = 1'b1;
        dif.i_clr_cnt  = 1'b0;

        #12;
        chk("rst.valid", 32'(dif.o_valid), 32'd0);
        chk("rst.ready", 32'(dif.o_ready), 32'd1);
        chk("rst.data", 32'(dif.o_data), 32'd0);
        chk("rst.sec", 32'(dif.o_sec), 32'd0);
        chk("rst.ded", 32'(dif.o_ded), 32'd0);
        chk("rst.pos", 32'(dif.o_err_pos), 32'd0);
        check_counts("rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply($sformatf("v%0d", i), vecs[i].cw, vecs[i].data, vecs[i].sec, vecs[i].ded,
                  vecs[i].pos, 1'b0);
        end

        // Backpressure: stall for 6 cycles while offering 3 words, then release.
        idx  = 0;
        nout = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            dif.i_ready = (c >= 6);
            if (idx < 3) begin
                dif.i_valid    = 1'b1;
                dif.i_codeword = bp_cw[idx];
            end else begin
                dif.i_valid = 1'b0;
            end
            #1;
            if (c >= 2 && c < 6) begin
                chk($sformatf("bp.hold_valid%0d", c), 32'(dif.o_valid), 32'd1);
                chk($sformatf("bp.hold_data%0d", c), 32'(dif.o_data), 32'hA5);
            end
            if (c == 5) begin
                chk("bp.accepted", 32'(idx), 32'd2);
                chk("bp.full_ready", 32'(dif.o_ready), 32'd0);
            end
            if (dif.o_valid && dif.i_ready) begin
                if (nout < 3) begin
                    out_cyc[nout] = c;
                    out_dat[nout] = dif.o_data;
                    out_sec[nout] = dif.o_sec;
                end
                nout++;
            end
            if (dif.i_valid && dif.o_ready) idx++;
        end
        dif.i_valid = 1'b0;
        chk("bp.nout", 32'(nout), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < nout) begin
                chk($sformatf("bp.out%0d.data", k), 32'(out_dat[k]), 32'(bp_data[k]));
                chk($sformatf("bp.out%0d.sec", k), 32'(out_sec[k]), 32'(bp_sec[k]));
                chk($sformatf("bp.out%0d.cycle", k), 32'(out_cyc[k]), 32'(6 + k));
            end
        end
        exp_sec += 1;

        // Standalone clear, then saturate the 2-bit twin, then clear against a SEC transfer.
        @(negedge clk);
        dif.i_clr_cnt = 1'b1;
        @(negedge clk);
        dif.i_clr_cnt = 1'b0;
        exp_sec = 0;
        exp_ded = 0;
        check_counts("clr");
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("sat%0d", i), 13'h0020, 8'h00, 1'b1, 1'b0, 4'd5, 1'b0);
        end
        chk("sat.final", 32'(sif.o_sec_count), 32'd3);
        apply("clr_sec", 13'h0008, 8'h00, 1'b1, 1'b0, 4'd3, 1'b1);

        // Asynchronous reset with a word held at the output.
        @(negedge clk);
        dif.i_ready    = 1'b0;
        dif.i_valid    = 1'b1;
        dif.i_codeword = 13'h0020;
        @(negedge clk);
        dif.i_valid = 1'b0;
        @(negedge clk);
        chk("arst.pre_valid", 32'(dif.o_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(dif.o_valid), 32'd0);
        chk("arst.ready", 32'(dif.o_ready), 32'd1);
        chk("arst.data", 32'(dif.o_data), 32'd0);
        chk("arst.sec", 32'(dif.o_sec), 32'd0);
        exp_sec = 0;
        exp_ded = 0;
        check_counts("arst");
        @(negedge clk);
        rst_n       = 1'b1;
        dif.i_ready = 1'b1;
        apply("post_rst", 13'h104E, 8'hA5, 1'b1, 1'b0, 4'd10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
